fifo_reader: RTL

Drains the team's synchronous FIFO from the read side and presents the words on a downstream valid/ready stream. The FIFO has a one-cycle read latency: a read accepted on edge N returns data with `data_out_valid` high during cycle N+1. This block issues FIFO reads, tracks the in-flight read, and absorbs returning data in a 2-entry skid buffer, so downstream backpressure never loses a word. It sits between the FIFO's rd/empty/data_out/data_out_valid pins and the consumer logic.

---
 rtl/fifo_reader_pkg.sv | 27 ++
 rtl/fifo_reader_skid.sv | 74 +++++++
 rtl/fifo_reader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_reader_pkg
//
// Purpose : Shared types and sizing constants for the FIFO read-side drainer
//           (fifo_reader) and its skid buffer (fifo_reader_skid).
//
// Contents:
//   state_t    - controller state encoding (IDLE / RUN / STOP)
//   SKID_DEPTH - number of words the skid buffer can hold
//   OCC_WIDTH  - width of the skid occupancy count (holds 0..SKID_DEPTH)
// -----------------------------------------------------------------------------
package fifo_reader_pkg;

   // Controller states. The encodings are fixed because other blocks of the
   // codebase decode them from debug taps.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   // Two entries are enough to cover the one-cycle FIFO read latency: one
   // word may sit in the buffer while a second one is still in flight.
   localparam int SKID_DEPTH = 2;
   localparam int OCC_WIDTH  = 2;

endpackage : fifo_reader_pkg

// File: rtl/fifo_reader_skid.sv
// -----------------------------------------------------------------------------
// fifo_reader_skid
//
// Purpose : Two-entry ordered skid buffer. Words are pushed behind the current
//           occupant and popped from the head. A simultaneous push and pop at
//           occupancy 1 replaces the head with the new word. When the buffer
//           is empty the head output keeps its last value.
//
// Ports:
//   clk        in   clock, rising edge
//   clear      in   synchronous active-high clear (empties buffer, zeroes data)
//   push       in   write push_data this cycle
//   push_data  in   [DATA_WIDTH] word to write
//   pop        in   remove the head this cycle (only when head_valid)
//   head_data  out  [DATA_WIDTH] oldest stored word
//   head_valid out  buffer holds at least one word
//   occ        out  [OCC_WIDTH] number of stored words, 0..SKID_DEPTH
//
// The caller guarantees that push never occurs at full occupancy without a
// pop in the same cycle, and that pop never occurs when empty.
// -----------------------------------------------------------------------------
module fifo_reader_skid
   import fifo_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_valid,
   output logic [OCC_WIDTH-1:0]  occ
);

   logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];

   // Slot the incoming word lands in: directly behind whatever remains after
   // this cycle's pop. Remaining words are 0 or 1 in every legal case, so
   // the push goes to the head when the buffer drains to empty and to the
   // tail otherwise.
   logic wr_slot;
   assign wr_slot = (occ == 2'd2) || ((occ == 2'd1) && !pop);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values; mixing in blocking writes here
   // would make the mem[0] <= mem[1] shift order-dependent.
   always_ff @(posedge clk) begin
      if (clear) begin
         occ <= '0;
         // NOTE: the storage is cleared along with the control state because
         // the head is visible on the output port and must read as zero after
         // a clear. Wider buffers without that need should leave data
         // registers out of the reset.
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         // Advance the tail into the head when the head leaves a full buffer.
         if (pop && (occ == 2'd2)) begin
            mem[0] <= mem[1];
         end
         if (push) begin
            mem[wr_slot] <= push_data;
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_data  = mem[0];
   assign head_valid = (occ != '0);

endmodule : fifo_reader_skid

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Purpose : Drains a synchronous FIFO with one-cycle read latency and presents
//           the words on a valid/ready stream. Reads are issued only when the
//           skid buffer has room for every word already in flight, so
//           downstream backpressure never drops data.
//
// Ports:
//   clk             in   clock, rising edge
//   clear           in   synchronous active-high reset
//   enable          in   level; 1 = keep draining the FIFO
//   fifo_rd         out  read strobe to the FIFO rd pin (combinational)
//   fifo_empty      in   FIFO empty flag
//   fifo_data       in   [DATA_WIDTH] FIFO data_out
//   fifo_data_valid in   FIFO data_out_valid (one cycle after an accepted read)
//   out_data        out  [DATA_WIDTH] head of the skid buffer
//   out_valid       out  skid buffer not empty
//   out_ready       in   downstream accept
//   busy            out  controller not IDLE
//   protocol_err    out  sticky; FIFO returned data with no read outstanding
//   word_count      out  [CNT_WIDTH] delivered-word counter, wraps; present
//                        only when RD_WORD_COUNT_EN is defined
//
// Configuration macro: RD_WORD_COUNT_EN adds the word_count port and counter.
//
// Timing: fifo_rd high in cycle N -> data returns in N+1 and is pushed at
// the end of N+1 -> out_valid is high in N+2.
// -----------------------------------------------------------------------------
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  enable,
   output logic                  fifo_rd,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_data_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  protocol_err
`ifdef RD_WORD_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  word_count
`endif
);

   if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
      $error("fifo_reader: DATA_WIDTH and CNT_WIDTH must both be at least 1");
   end

   state_t               state;
   logic                 inflight;
   logic                 push;
   logic                 pop;
   logic [OCC_WIDTH-1:0] occ;
   logic [OCC_WIDTH:0]   reserved;

   assign pop  = out_valid & out_ready;
   // Only data answering one of our own reads is accepted; anything else is
   // flagged below and dropped.
   assign push = fifo_data_valid & inflight;

   // Buffer slots that will be spoken for after this cycle: words stored plus
   // the word still returning, minus the word leaving now. A new read is
   // allowed only if its data is guaranteed a slot.
   assign reserved = {1'b0, occ}
                   + {{OCC_WIDTH{1'b0}}, inflight}
                   - {{OCC_WIDTH{1'b0}}, pop};

   assign fifo_rd = !clear
                 && (state == RUN)
                 && !fifo_empty
                 && (reserved < (OCC_WIDTH + 1)'(SKID_DEPTH));

   assign busy = (state != IDLE);

   // Controller: state, in-flight tracking and the sticky error flag.
   always_ff @(posedge clk) begin
      if (clear) begin
         state        <= IDLE;
         inflight     <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         // The FIFO answers every accepted read exactly one cycle later.
         inflight <= fifo_rd;

         if (fifo_data_valid && !inflight) begin
            protocol_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (enable) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!enable) begin
                  state <= STOP;
               end
            end
            STOP: begin
               // Stay busy until the outstanding read has landed and the
               // consumer has taken every buffered word.
               if (enable) begin
                  state <= RUN;
               end else if ((occ == '0) && !inflight && !push) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fifo_reader_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .clear      (clear),
      .push       (push),
      .push_data  (fifo_data),
      .pop        (pop),
      .head_data  (out_data),
      .head_valid (out_valid),
      .occ        (occ)
   );

`ifdef RD_WORD_COUNT_EN
   // Counts words accepted downstream; wraps naturally at 2**CNT_WIDTH.
   always_ff @(posedge clk) begin
      if (clear) begin
         word_count <= '0;
      end else if (pop) begin
         word_count <= word_count + CNT_WIDTH'(1);
      end
   end
`endif

endmodule : fifo_reader
